// File: rtl/scheduler_sched_info_ctrl.sv
// ----------------------------------------------------------------------------
// scheduler_sched_info_ctrl
//   Front-end controller for the per-accelerator-type schedule-info RAM.
//   Port A of the RAM takes entry writes from the command/config path, port B
//   serves lookups from the scheduler FSM with one cycle of read latency.
//   The block keeps a valid bitmap and a count of valid entries. It stalls a
//   lookup that collides with a same-cycle write to the same entry, and it
//   returns lookup responses over a valid/ready handshake.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   clear                 1-cycle pulse, invalidates every entry (RAM untouched)
//   wr_valid/ready/addr/data   entry write request
//   rd_req_valid/ready/addr    lookup request
//   rd_rsp_valid/ready/data/hit lookup response (data is 0 on a miss)
//   num_valid             number of valid entries
//   ram_a_addr/en/din     RAM write port
//   ram_b_addr/en         RAM read port request
//   ram_b_dout            RAM read data, registered inside the RAM
// ----------------------------------------------------------------------------
module scheduler_sched_info_ctrl #(
    parameter int MAX_ACC_TYPES = 16,
    parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ACC_TYPE_BITS-1:0] wr_addr,
    input  logic [49:0]              wr_data,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  logic [ACC_TYPE_BITS-1:0] rd_req_addr,
    output logic                     rd_rsp_valid,
    input  logic                     rd_rsp_ready,
    output logic [49:0]              rd_rsp_data,
    output logic                     rd_rsp_hit,
    output logic [ACC_TYPE_BITS:0]   num_valid,
    output logic [ACC_TYPE_BITS-1:0] ram_a_addr,
    output logic                     ram_a_en,
    output logic [49:0]              ram_a_din,
    output logic [ACC_TYPE_BITS-1:0] ram_b_addr,
    output logic                     ram_b_en,
    input  logic [49:0]              ram_b_dout
);

    localparam int NV_W = ACC_TYPE_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic                     live_r;
    logic [1:0]               stall_cnt_r;
    logic [MAX_ACC_TYPES-1:0] bitmap_r;
    logic [MAX_ACC_TYPES-1:0] bitmap_s;
    logic [NV_W-1:0]          num_valid_r;
    logic [NV_W-1:0]          num_valid_s;
    logic                     hit_r;
    logic [49:0]              rsp_data_r;

    logic                     guard_s;
    logic                     wr_ready_s;
    logic                     wr_fire_s;
    logic                     hazard_s;
    logic                     rd_req_ready_s;
    logic                     rd_fire_s;
    logic                     rsp_valid_s;
    logic [49:0]              rsp_data_s;

    // Handshake decode: starvation guard, write acceptance and the read/write hazard.
    always_comb begin
        // After two stalled cycles the waiting lookup wins one cycle over writes.
        guard_s        = (state_r == ST_IDLE) && (stall_cnt_r == 2'd2) && rd_req_valid;
        wr_ready_s     = !guard_s;
        wr_fire_s      = wr_valid && wr_ready_s;
        // A read racing a write to the same entry is held off rather than returning mixed data.
        hazard_s       = wr_fire_s && (wr_addr == rd_req_addr);
        rd_req_ready_s = live_r && (state_r == ST_IDLE) && !hazard_s;
        rd_fire_s      = rd_req_valid && rd_req_ready_s;
    end

    // Next valid bitmap and count; a write in the clear cycle survives the clear.
    always_comb begin
        bitmap_s    = bitmap_r;
        num_valid_s = num_valid_r;
        if (clear) begin
            bitmap_s    = {MAX_ACC_TYPES{1'b0}};
            num_valid_s = {NV_W{1'b0}};
            if (wr_fire_s) begin
                bitmap_s[wr_addr] = 1'b1;
                num_valid_s       = {{ACC_TYPE_BITS{1'b0}}, 1'b1};
            end else begin
                bitmap_s = {MAX_ACC_TYPES{1'b0}};
            end
        end else if (wr_fire_s) begin
            bitmap_s[wr_addr] = 1'b1;
            if (!bitmap_r[wr_addr]) begin
                num_valid_s = num_valid_r + {{ACC_TYPE_BITS{1'b0}}, 1'b1};
            end else begin
                num_valid_s = num_valid_r;
            end
        end else begin
            bitmap_s    = bitmap_r;
            num_valid_s = num_valid_r;
        end
    end

    // Lookup FSM next state and response output selection.
    always_comb begin
        state_s     = state_r;
        rsp_valid_s = 1'b0;
        rsp_data_s  = 50'h0;
        case (state_r)
            ST_IDLE: begin
                if (rd_fire_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // RAM output is already valid here, so the response goes out at once.
                rsp_valid_s = 1'b1;
                rsp_data_s  = hit_r ? ram_b_dout : 50'h0;
                if (rd_rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_RESP: begin
                // Held copy keeps the response stable no matter what port A does.
                rsp_valid_s = 1'b1;
                rsp_data_s  = rsp_data_r;
                if (rd_rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, bitmap, counters and the latched lookup result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            live_r      <= 1'b0;
            stall_cnt_r <= 2'd0;
            bitmap_r    <= {MAX_ACC_TYPES{1'b0}};
            num_valid_r <= {NV_W{1'b0}};
            hit_r       <= 1'b0;
            rsp_data_r  <= 50'h0;
        end else begin
            state_r     <= state_s;
            live_r      <= 1'b1;
            bitmap_r    <= bitmap_s;
            num_valid_r <= num_valid_s;
            if ((state_r == ST_IDLE) && rd_req_valid && live_r && hazard_s) begin
                stall_cnt_r <= (stall_cnt_r == 2'd2) ? 2'd2 : stall_cnt_r + 2'd1;
            end else begin
                stall_cnt_r <= 2'd0;
            end
            if (rd_fire_s) begin
                hit_r <= bitmap_r[rd_req_addr];
            end else begin
                hit_r <= hit_r;
            end
            if (state_r == ST_READ) begin
                rsp_data_r <= hit_r ? ram_b_dout : 50'h0;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign wr_ready     = wr_ready_s;
    assign rd_req_ready = rd_req_ready_s;
    assign ram_a_en     = wr_fire_s;
    assign ram_a_addr   = wr_addr;
    assign ram_a_din    = wr_data;
    assign ram_b_en     = rd_fire_s;
    assign ram_b_addr   = rd_req_addr;
    assign rd_rsp_valid = rsp_valid_s;
    assign rd_rsp_data  = rsp_data_s;
    assign rd_rsp_hit   = hit_r;
    assign num_valid    = num_valid_r;

endmodule

// File: tb/tb_scheduler_sched_info_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scheduler_sched_info_ctrl
//   Directed bench for scheduler_sched_info_ctrl with a behavioural RAM model
//   (port A write, port B registered read). Expected values are hand-written.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scheduler_sched_info_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [49:0] wr_data;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [3:0]  rd_req_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [49:0] rd_rsp_data;
    logic        rd_rsp_hit;
    logic [4:0]  num_valid;
    logic [3:0]  ram_a_addr;
    logic        ram_a_en;
    logic [49:0] ram_a_din;
    logic [3:0]  ram_b_addr;
    logic        ram_b_en;
    logic [49:0] ram_b_dout = 50'h0;
    logic [49:0] mem [16] = '{default: 50'h0};

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [49:0] VAL_A  = 50'h2_0000_0000_ABCD;
    localparam logic [49:0] VAL_A2 = 50'h0_1111_2222_3333;
    localparam logic [49:0] VAL_X  = 50'h1_5555_0000_0005;
    localparam logic [49:0] VAL_X2 = 50'h0_5555_FFFF_0005;
    localparam logic [49:0] VAL_Y  = 50'h1_6666_0000_0006;
    localparam logic [49:0] VAL_V0 = 50'h0_7777_0000_0000;
    localparam logic [49:0] VAL_V1 = 50'h0_7777_0000_0001;
    localparam logic [49:0] VAL_V2 = 50'h0_7777_0000_0002;
    localparam logic [49:0] VAL_W  = 50'h3_1234_5678_9ABC;

    always #5 clk = ~clk;

    scheduler_sched_info_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_hit   (rd_rsp_hit),
        .num_valid    (num_valid),
        .ram_a_addr   (ram_a_addr),
        .ram_a_en     (ram_a_en),
        .ram_a_din    (ram_a_din),
        .ram_b_addr   (ram_b_addr),
        .ram_b_en     (ram_b_en),
        .ram_b_dout   (ram_b_dout)
    );

    // Behavioural schedule-info RAM.
    always @(posedge clk) begin
        if (ram_a_en) mem[ram_a_addr] <= ram_a_din;
        if (ram_b_en) ram_b_dout <= mem[ram_b_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One accepted write; inputs set just after a falling edge.
    task automatic write_entry(input logic [3:0] a, input logic [49:0] d, input string tag);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        check_val({tag, "_wr_ready"}, {63'h0, wr_ready}, 64'h1);
        check_val({tag, "_ram_a"}, {9'h0, ram_a_en, ram_a_addr, ram_a_din}, {9'h0, 1'b1, a, d});
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Lookup with response expected in the cycle after acceptance.
    task automatic lookup(input logic [3:0] a, input logic exp_hit, input logic [49:0] exp_data,
                          input string tag);
        int n;
        rd_req_valid = 1'b1; rd_req_addr = a;
        #1;
        n = 0;
        while (!rd_req_ready && n < 8) begin
            @(negedge clk); #1; n++;
        end
        check_val({tag, "_accept"}, {63'h0, rd_req_ready}, 64'h1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        check_val({tag, "_rsp_valid"}, {63'h0, rd_rsp_valid}, 64'h1);
        check_val({tag, "_hit"}, {63'h0, rd_rsp_hit}, {63'h0, exp_hit});
        check_val({tag, "_data"}, {14'h0, rd_rsp_data}, {14'h0, exp_data});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_addr = 4'h0; wr_data = 50'h0;
        rd_req_valid = 1'b0; rd_req_addr = 4'h0; rd_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rd_req_valid = 1'b1;
        #1;
        check_val("rst_num_valid", {59'h0, num_valid}, 64'h0);
        check_val("rst_rsp_valid", {63'h0, rd_rsp_valid}, 64'h0);
        check_val("rst_rsp_hit", {63'h0, rd_rsp_hit}, 64'h0);
        check_val("rst_wr_ready", {63'h0, wr_ready}, 64'h1);
        check_val("rst_rd_req_ready", {63'h0, rd_req_ready}, 64'h0);
        check_val("rst_ram_en", {62'h0, ram_a_en, ram_b_en}, 64'h0);
        rd_req_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: lookup of an empty entry
        lookup(4'd3, 1'b0, 50'h0, "t1_miss");
        check_val("t1_num_valid", {59'h0, num_valid}, 64'h0);
        check_val("t1_idle_rsp", {63'h0, rd_rsp_valid}, 64'h0);

        // 2: write, lookup, rewrite
        write_entry(4'd3, VAL_A, "t2_w");
        lookup(4'd3, 1'b1, VAL_A, "t2_hit");
        check_val("t2_num_valid", {59'h0, num_valid}, 64'h1);
        write_entry(4'd3, VAL_A2, "t2_rw");
        check_val("t2_num_rewrite", {59'h0, num_valid}, 64'h1);
        lookup(4'd3, 1'b1, VAL_A2, "t2_hit2");

        // 3: same-address hazard stalls one cycle; different address does not
        write_entry(4'd6, VAL_Y, "t3_w6");
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = VAL_X;
        rd_req_valid = 1'b1; rd_req_addr = 4'd5;
        #1;
        check_val("t3_stall", {63'h0, rd_req_ready}, 64'h0);
        check_val("t3_stall_ram_b", {63'h0, ram_b_en}, 64'h0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check_val("t3_after_stall", {63'h0, rd_req_ready}, 64'h1);
        lookup(4'd5, 1'b1, VAL_X, "t3_same");
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = VAL_X2;
        rd_req_valid = 1'b1; rd_req_addr = 4'd6;
        #1;
        check_val("t3_nostall", {63'h0, rd_req_ready}, 64'h1);
        check_val("t3_concurrent", {62'h0, ram_a_en, ram_b_en}, 64'h3);
        @(negedge clk);
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        #1;
        check_val("t3_diff_hit", {63'h0, rd_rsp_hit}, 64'h1);
        check_val("t3_diff_data", {14'h0, rd_rsp_data}, {14'h0, VAL_Y});
        @(negedge clk);
        check_val("t3_num_valid", {59'h0, num_valid}, 64'h3);

        // 4: starvation guard
        rd_req_valid = 1'b1; rd_req_addr = 4'd7;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = VAL_V0;
        #1;
        check_val("t4_c0_wr_ready", {63'h0, wr_ready}, 64'h1);
        check_val("t4_c0_stall", {63'h0, rd_req_ready}, 64'h0);
        @(negedge clk);
        wr_data = VAL_V1;
        #1;
        check_val("t4_c1_wr_ready", {63'h0, wr_ready}, 64'h1);
        check_val("t4_c1_stall", {63'h0, rd_req_ready}, 64'h0);
        @(negedge clk);
        wr_data = VAL_V2;
        #1;
        check_val("t4_guard_wr_ready", {63'h0, wr_ready}, 64'h0);
        check_val("t4_guard_accept", {63'h0, rd_req_ready}, 64'h1);
        check_val("t4_guard_ram_a", {63'h0, ram_a_en}, 64'h0);
        @(negedge clk);
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        #1;
        check_val("t4_rsp_valid", {63'h0, rd_rsp_valid}, 64'h1);
        check_val("t4_hit", {63'h0, rd_rsp_hit}, 64'h1);
        check_val("t4_data", {14'h0, rd_rsp_data}, {14'h0, VAL_V1});
        @(negedge clk);
        check_val("t4_num_valid", {59'h0, num_valid}, 64'h4);

        // 5: fill, then clear together with a write to entry 2
        for (int i = 0; i < 16; i++) begin
            write_entry(i[3:0], {46'h0, i[3:0]}, "t5_fill");
        end
        check_val("t5_full", {59'h0, num_valid}, 64'd16);
        lookup(4'd9, 1'b1, 50'h9, "t5_full_hit");
        clear = 1'b1; wr_valid = 1'b1; wr_addr = 4'd2; wr_data = VAL_W;
        @(negedge clk);
        clear = 1'b0; wr_valid = 1'b0;
        #1;
        check_val("t5_clear_num", {59'h0, num_valid}, 64'h1);
        @(negedge clk);
        lookup(4'd2, 1'b1, VAL_W, "t5_e2");
        lookup(4'd3, 1'b0, 50'h0, "t5_e3");
        lookup(4'd15, 1'b0, 50'h0, "t5_e15");

        // 6: response held under back-pressure while its entry is rewritten, then reset
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 4'd2;
        #1;
        check_val("t6_accept", {63'h0, rd_req_ready}, 64'h1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = 4'd2; wr_data = VAL_W + 50'(k + 1);
            #1;
            check_val("t6_hold_valid", {63'h0, rd_rsp_valid}, 64'h1);
            check_val("t6_hold_data", {14'h0, rd_rsp_data}, {14'h0, VAL_W});
            check_val("t6_hold_busy", {63'h0, rd_req_ready}, 64'h0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        check_val("t6_held_data", {14'h0, rd_rsp_data}, {14'h0, VAL_W});
        rst = 1'b1;
        #1;
        check_val("t6_rst_rsp_valid", {63'h0, rd_rsp_valid}, 64'h0);
        check_val("t6_rst_num_valid", {59'h0, num_valid}, 64'h0);
        check_val("t6_rst_hit", {63'h0, rd_rsp_hit}, 64'h0);
        @(negedge clk);
        rst = 1'b0; rd_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t6_post_rsp_valid", {63'h0, rd_rsp_valid}, 64'h0);
        lookup(4'd2, 1'b0, 50'h0, "t6_post_miss");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
